cache_control_fsm: RTL
======================

// Module: cache_control_fsm
// PURPOSE
//  Sequencing FSM for a direct-mapped, write-back cache built from the 2**S_INDEX-entry
//  tag/valid/dirty/data arrays (write-first bypass on same-index read). Accepts one CPU
//  request at a time, checks hit, writes back dirty victims, fills from physical memory and
//  drives every array load enable and mux select. Sits between CPU port and cacheline adaptor.
// PARAMETERS
//  S_INDEX   3    index width; array depth = 2**S_INDEX
//  WAIT_MAX  255  max cycles to wait for pmem_resp before abort; 0 = never abort
// PORTS
//  clk           in   1        rising-edge clock
//  rst_n         in   1        asynchronous reset, active low
//  mem_read      in   1        CPU read request, held until mem_resp
//  mem_write     in   1        CPU write request, held until mem_resp (never both with mem_read)
//  cpu_index     in   S_INDEX  set index of CPU address
//  hit           in   1        datapath tag compare == (stored tag == CPU tag), valid-qualified
//  dirty         in   1        dirty bit of indexed line (array dataout)
//  pmem_resp     in   1        physical-memory burst complete (one-cycle pulse)
//  mem_resp      out  1        one-cycle CPU completion pulse
//  pmem_read     out  1        line fill request
//  pmem_write    out  1        line write-back request
//  line_index    out  S_INDEX  latched index, drives rindex and windex of all arrays
//  load_data     out  1        data array write enable
//  data_sel      out  1        0 = CPU write merge, 1 = pmem line
//  load_tag      out  1        tag array write enable
//  load_valid    out  1        valid array write enable (datain fixed 1)
//  load_dirty    out  1        dirty array write enable
//  dirty_in      out  1        dirty array datain
//  wb_addr_sel   out  1        1 = pmem address from stored tag (victim), 0 = CPU tag
//  err           out  1        one-cycle pulse on pmem timeout
// BEHAVIOUR
//  States: IDLE, CHECK, WB, FILL. All outputs combinational from state + inputs, except
//   line_index (register). Reset: state=IDLE, line_index=0, wait counter=0, all outputs 0;
//   reset asserted mid-WB/FILL drops pmem_read/pmem_write immediately (asynchronously).
//  IDLE: all enables 0. If mem_read|mem_write: line_index<=cpu_index, ->CHECK.
//  CHECK: hit & read -> mem_resp=1, ->IDLE.
//   hit & write -> load_data=1, data_sel=0, load_dirty=1, dirty_in=1, mem_resp=1, ->IDLE.
//   miss & dirty -> ->WB. miss & !dirty -> ->FILL.
//  WB: pmem_write=1, wb_addr_sel=1 until pmem_resp; on pmem_resp ->FILL.
//  FILL: pmem_read=1; on pmem_resp: load_data=1, data_sel=1, load_tag=1, load_valid=1,
//   load_dirty=1, dirty_in=0, ->CHECK (re-check hits, completes request).
//  Latency: read hit = mem_resp in 2nd cycle after request seen; clean miss = 2 + fill + 1;
//   dirty miss = 2 + wb + fill + 1.
//  Wait counter: cleared on entry to WB/FILL, +1 per cycle without pmem_resp; when it reaches
//   WAIT_MAX (WAIT_MAX!=0): err=1, mem_resp=1, no array loads, ->IDLE. Saturates, never wraps.
//  pmem_resp outside WB/FILL ignored. Request dropped by CPU mid-transaction: FSM still
//   completes current state sequence (line integrity); mem_resp still pulsed.
//  line_index only updates in IDLE; cpu_index changes in other states are ignored.
//  Back-to-back: new request in the cycle after mem_resp is accepted from IDLE.
// TESTING
//  1 Reset: rst_n=0 mid-FILL with pmem_read=1 -> pmem_read=0 same cycle, state IDLE, all out 0.
//  2 Read hit: mem_read=1, cpu_index=5, hit=1 -> line_index=5, mem_resp=1 exactly cycle 2, no loads.
//  3 Write hit: mem_write=1, hit=1 -> load_data=1, data_sel=0, load_dirty=1, dirty_in=1, mem_resp in CHECK.
//  4 Dirty miss: hit=0, dirty=1, pmem_resp after 4 cyc (WB) and 6 cyc (FILL) -> pmem_write 4 cyc
//    with wb_addr_sel=1, pmem_read 6 cyc, fill loads on resp cycle, hit=1 -> mem_resp next cycle.
//  5 Timeout: WAIT_MAX=8, clean miss, pmem_resp never -> err=1 & mem_resp=1 on 8th FILL cycle, no loads.
//  6 Index hold: change cpu_index 5->2 during FILL -> line_index stays 5; stray pmem_resp in IDLE ignored.

Source files
------------

// File: rtl/cache_control_fsm.sv
// Sequencing FSM for a direct-mapped write-back cache: hit check, dirty victim
// write-back, line fill from physical memory, and all array load enables / mux selects.
module cache_control_fsm #(
  parameter int unsigned S_INDEX  = 3,
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_read_i,
  input  logic               mem_write_i,
  input  logic [S_INDEX-1:0] cpu_index_i,
  input  logic               hit_i,
  input  logic               dirty_i,
  input  logic               pmem_resp_i,
  output logic               mem_resp_o,
  output logic               pmem_read_o,
  output logic               pmem_write_o,
  output logic [S_INDEX-1:0] line_index_o,
  output logic               load_data_o,
  output logic               data_sel_o,
  output logic               load_tag_o,
  output logic               load_valid_o,
  output logic               load_dirty_o,
  output logic               dirty_in_o,
  output logic               wb_addr_sel_o,
  output logic               err_o
);

  localparam int unsigned      CNT_W    = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_MAX == 0) ? 0 : WAIT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam bit               ABORT_EN = (WAIT_MAX != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WB    = 2'd2,
    FILL  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [S_INDEX-1:0] line_index_q, line_index_d;
  logic               is_write_q, is_write_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      line_index_q <= '0;
      is_write_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      line_index_q <= line_index_d;
      is_write_q   <= is_write_d;
      cnt_q        <= cnt_d;
    end
  end

  // Saturating wait counter; abort fires on the cycle it would reach WAIT_MAX.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout = ABORT_EN && !pmem_resp_i && (cnt_q == CNT_LAST);

  always_comb begin
    state_d       = state_q;
    line_index_d  = line_index_q;
    is_write_d    = is_write_q;
    cnt_d         = cnt_q;
    mem_resp_o    = 1'b0;
    pmem_read_o   = 1'b0;
    pmem_write_o  = 1'b0;
    load_data_o   = 1'b0;
    data_sel_o    = 1'b0;
    load_tag_o    = 1'b0;
    load_valid_o  = 1'b0;
    load_dirty_o  = 1'b0;
    dirty_in_o    = 1'b0;
    wb_addr_sel_o = 1'b0;
    err_o         = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_read_i || mem_write_i) begin
          line_index_d = cpu_index_i;
          is_write_d   = mem_write_i;
          state_d      = CHECK;
        end
      end
      // Operation is latched at accept so a dropped request still completes cleanly.
      CHECK: begin
        if (hit_i) begin
          mem_resp_o = 1'b1;
          if (is_write_q) begin
            load_data_o  = 1'b1;
            load_dirty_o = 1'b1;
            dirty_in_o   = 1'b1;
          end
          state_d = IDLE;
        end else begin
          cnt_d   = '0;
          state_d = dirty_i ? WB : FILL;
        end
      end
      WB: begin
        pmem_write_o  = 1'b1;
        wb_addr_sel_o = 1'b1;
        if (pmem_resp_i) begin
          cnt_d   = '0;
          state_d = FILL;
        end else if (timeout) begin
          err_o      = 1'b1;
          mem_resp_o = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      FILL: begin
        pmem_read_o = 1'b1;
        if (pmem_resp_i) begin
          load_data_o  = 1'b1;
          data_sel_o   = 1'b1;
          load_tag_o   = 1'b1;
          load_valid_o = 1'b1;
          load_dirty_o = 1'b1;
          state_d      = CHECK;
        end else if (timeout) begin
          err_o      = 1'b1;
          mem_resp_o = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign line_index_o = line_index_q;

endmodule
